// File: rtl/palette_writer.sv
// Double-buffered palette loader: streams host colour words into the hidden bank, swaps banks at a frame boundary.
// Optional running checksum of loaded words is enabled with macro PALETTE_WRITER_CHECKSUM_EN.
module palette_writer #(
    parameter int RBG_SIZE   = 24,
    parameter int LUT_SIZE   = 256,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  frame_start,
    input  logic                  s_valid,
    input  logic [RBG_SIZE-1:0]   s_data,
    output logic                  s_ready,
    output logic                  wr_en,
    output logic                  wr_bank,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [RBG_SIZE-1:0]   wr_data,
    output logic                  bank_sel,
    output logic                  busy,
    output logic                  done,
    output logic [RBG_SIZE-1:0]   checksum
);

    typedef enum logic [1:0] {IDLE, LOAD, WAIT_SWAP} state_t;

    localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(LUT_SIZE - 1);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [RBG_SIZE-1:0]   wr_data_q, wr_data_d;
    logic                  bank_q, bank_d;
    logic                  wr_en_q, wr_en_d;
    logic                  done_q, done_d;
    logic                  xfer;
    logic                  loadStart;

    assign xfer      = (state_q == LOAD) && s_valid;
    assign loadStart = (state_q == IDLE) && start;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        bank_d    = bank_q;
        wr_en_d   = 1'b0;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (loadStart) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                end
            end
            LOAD: begin
                if (xfer) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = cnt_q;
                    wr_data_d = s_data;
                    cnt_d     = cnt_q + 1'b1;
                    if (cnt_q == LastAddr) state_d = WAIT_SWAP;
                end
            end
            // frame_start on the final-transfer cycle is seen in LOAD, so the swap waits for the next one
            WAIT_SWAP: begin
                if (frame_start) begin
                    bank_d  = ~bank_q;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            bank_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            bank_q    <= bank_d;
            wr_en_q   <= wr_en_d;
            done_q    <= done_d;
        end
    end

`ifdef PALETTE_WRITER_CHECKSUM_EN
    logic [RBG_SIZE-1:0] sum_q, sum_d;

    always_comb begin
        sum_d = sum_q;
        if (loadStart) sum_d = '0;
        else if (xfer) sum_d = sum_q + s_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sum_q <= '0;
        else        sum_q <= sum_d;
    end

    assign checksum = sum_q;
`else
    assign checksum = '0;
`endif

    assign s_ready  = (state_q == LOAD);
    assign busy     = (state_q != IDLE);
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign bank_sel = bank_q;
    assign wr_bank  = ~bank_q;
    assign done     = done_q;

endmodule

// File: tb/tb_palette_writer.sv
// Directed self-checking bench for palette_writer: full loads, stalls, frame-swap timing, mid-load reset, checksum.
module tb_palette_writer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        frame_start;
    logic        s_valid;
    logic [23:0] s_data;
    logic        s_ready;
    logic        wr_en;
    logic        wr_bank;
    logic [7:0]  wr_addr;
    logic [23:0] wr_data;
    logic        bank_sel;
    logic        busy;
    logic        done;
    logic [23:0] checksum;

    int checks   = 0;
    int failures = 0;

`ifdef PALETTE_WRITER_CHECKSUM_EN
    localparam logic [31:0] SumRamp = 32'h0000_7F80;
    localparam logic [31:0] SumOnes = 32'h00FF_FF00;
`else
    localparam logic [31:0] SumRamp = 32'h0;
    localparam logic [31:0] SumOnes = 32'h0;
`endif

    palette_writer #(.RBG_SIZE(24), .LUT_SIZE(256), .ADDR_WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .frame_start(frame_start),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .wr_en      (wr_en),
        .wr_bank    (wr_bank),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .bank_sel   (bank_sel),
        .busy       (busy),
        .done       (done),
        .checksum   (checksum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs, then let a rising edge pass and settle before sampling.
    task automatic applyStimulus(input logic v, input logic [23:0] d, input logic fs, input logic st);
        s_valid     = v;
        s_data      = d;
        frame_start = fs;
        start       = st;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        frame_start = 1'b0;
        s_valid = 1'b0;
        s_data = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("rst_wr_en",    32'(wr_en),    0);
        checkOutput("rst_wr_addr",  32'(wr_addr),  0);
        checkOutput("rst_wr_data",  32'(wr_data),  0);
        checkOutput("rst_bank_sel", 32'(bank_sel), 0);
        checkOutput("rst_wr_bank",  32'(wr_bank),  1);
        checkOutput("rst_busy",     32'(busy),     0);
        checkOutput("rst_s_ready",  32'(s_ready),  0);
        checkOutput("rst_done",     32'(done),     0);
        checkOutput("rst_checksum", 32'(checksum), 0);

        rst_n = 1'b1;
        applyStimulus(1'b0, 24'h0, 1'b0, 1'b1);
        checkOutput("l1_busy",    32'(busy),    1);
        checkOutput("l1_s_ready", 32'(s_ready), 1);
        checkOutput("l1_wr_en0",  32'(wr_en),   0);

        // Load 1: ramp data, s_valid held, frame_start coincident with the last transfer
        for (int i = 0; i < 256; i++) begin
            applyStimulus(1'b1, 24'(i), (i == 255), 1'b0);
            checkOutput("l1_wr_en",   32'(wr_en),   1);
            checkOutput("l1_wr_addr", 32'(wr_addr), 32'(i));
            checkOutput("l1_wr_data", 32'(wr_data), 32'(i));
            checkOutput("l1_wr_bank", 32'(wr_bank), 1);
        end
        checkOutput("l1_end_s_ready",  32'(s_ready),  0);
        checkOutput("l1_end_busy",     32'(busy),     1);
        checkOutput("l1_end_bank_sel", 32'(bank_sel), 0);
        checkOutput("l1_end_done",     32'(done),     0);
        checkOutput("l1_checksum",     32'(checksum), SumRamp);

        applyStimulus(1'b0, 24'h0, 1'b0, 1'b0);
        checkOutput("ws_wr_en",    32'(wr_en),    0);
        checkOutput("ws_bank_sel", 32'(bank_sel), 0);
        checkOutput("ws_busy",     32'(busy),     1);

        applyStimulus(1'b1, 24'h123456, 1'b0, 1'b1);
        checkOutput("ws_start_busy",    32'(busy),    1);
        checkOutput("ws_start_s_ready", 32'(s_ready), 0);
        checkOutput("ws_start_wr_en",   32'(wr_en),   0);

        applyStimulus(1'b0, 24'h0, 1'b1, 1'b0);
        checkOutput("sw1_bank_sel", 32'(bank_sel), 1);
        checkOutput("sw1_wr_bank",  32'(wr_bank),  0);
        checkOutput("sw1_done",     32'(done),     1);
        checkOutput("sw1_busy",     32'(busy),     0);
        checkOutput("sw1_checksum", 32'(checksum), SumRamp);

        applyStimulus(1'b0, 24'h0, 1'b1, 1'b0);
        checkOutput("idle_fs_done",     32'(done),     0);
        checkOutput("idle_fs_bank_sel", 32'(bank_sel), 1);
        checkOutput("idle_fs_busy",     32'(busy),     0);

        // Abandoned load: reset after 100 transfers
        applyStimulus(1'b0, 24'h0, 1'b0, 1'b1);
        for (int i = 0; i < 100; i++) begin
            applyStimulus(1'b1, 24'hFFFFFF, 1'b0, 1'b0);
        end
        checkOutput("pre_rst_wr_addr", 32'(wr_addr), 99);
        s_valid = 1'b0;
        rst_n   = 1'b0;
        #1;
        checkOutput("mid_rst_busy",     32'(busy),     0);
        checkOutput("mid_rst_wr_en",    32'(wr_en),    0);
        checkOutput("mid_rst_bank_sel", 32'(bank_sel), 0);
        checkOutput("mid_rst_wr_addr",  32'(wr_addr),  0);
        checkOutput("mid_rst_wr_data",  32'(wr_data),  0);
        checkOutput("mid_rst_checksum", 32'(checksum), 0);
        checkOutput("mid_rst_done",     32'(done),     0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(1'b0, 24'h0, 1'b0, 1'b0);
        checkOutput("post_rst_done", 32'(done), 0);
        checkOutput("post_rst_busy", 32'(busy), 0);

        // Load 2: ramp data with s_valid toggling; stray frame_start and start mid-load
        applyStimulus(1'b0, 24'h0, 1'b0, 1'b1);
        checkOutput("l2_busy", 32'(busy), 1);
        for (int c = 0; c < 511; c++) begin
            if (c % 2 == 0) begin
                applyStimulus(1'b1, 24'(c / 2), (c == 4), (c == 50));
                checkOutput("l2_wr_en",   32'(wr_en),   1);
                checkOutput("l2_wr_addr", 32'(wr_addr), 32'(c / 2));
                checkOutput("l2_wr_data", 32'(wr_data), 32'(c / 2));
            end else begin
                applyStimulus(1'b0, 24'h5A5A5A, (c == 3), 1'b0);
                checkOutput("l2_stall_wr_en",   32'(wr_en),   0);
                checkOutput("l2_stall_s_ready", 32'(s_ready), 1);
            end
        end
        checkOutput("l2_bank_sel",   32'(bank_sel), 0);
        checkOutput("l2_end_s_ready", 32'(s_ready), 0);
        checkOutput("l2_checksum",   32'(checksum), SumRamp);
        applyStimulus(1'b0, 24'h0, 1'b1, 1'b0);
        checkOutput("sw2_bank_sel", 32'(bank_sel), 1);
        checkOutput("sw2_done",     32'(done),     1);
        applyStimulus(1'b0, 24'h0, 1'b0, 1'b0);
        checkOutput("sw2_done_low", 32'(done), 0);

        // Load 3: all-ones words, checksum wraps
        applyStimulus(1'b0, 24'h0, 1'b0, 1'b1);
        for (int i = 0; i < 256; i++) begin
            applyStimulus(1'b1, 24'hFFFFFF, 1'b0, 1'b0);
            checkOutput("l3_wr_addr", 32'(wr_addr), 32'(i));
            checkOutput("l3_wr_data", 32'(wr_data), 32'h00FFFFFF);
            checkOutput("l3_wr_bank", 32'(wr_bank), 0);
        end
        checkOutput("l3_checksum", 32'(checksum), SumOnes);
        applyStimulus(1'b0, 24'h0, 1'b1, 1'b0);
        checkOutput("sw3_bank_sel", 32'(bank_sel), 0);
        checkOutput("sw3_wr_bank",  32'(wr_bank),  1);
        checkOutput("sw3_done",     32'(done),     1);
        checkOutput("sw3_checksum", 32'(checksum), SumOnes);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
